video_mem_arbiter: RTL and testbench

Two-requester arbiter sharing one single-port memory bus between the CPU data port and the video line-fetch engine that feeds the video block's pixel path. Video fetches have fixed priority so scanout does not starve. A wait counter bounds CPU latency. Exactly one transaction is outstanding on the memory port at a time, and every response is routed back to the requester that issued it.

---
 rtl/video_pkg.sv | 13 +
 rtl/video_mem_arbiter.sv | 112 +++++++++++
 tb/tb_video_mem_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared state encodings and constants for the video memory arbiter
package video_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_BUSY_CPU = 2'd1,
    ARB_BUSY_VID = 2'd2,
    ARB_RESP     = 2'd3
  } arb_state_t;

  localparam logic [3:0] WREN_READ = 4'b0000;

endpackage

// File: rtl/video_mem_arbiter.sv
// rtl/video_mem_arbiter.sv - CPU/video arbiter for one single-port memory bus, video priority with bounded CPU wait
module video_mem_arbiter
  import video_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int MAX_CPU_WAIT = 16
) (
  input  logic              clk_cpu,
  input  logic              n_reset,
  input  logic              cpu_sel,
  input  logic [3:0]        cpu_wren,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [31:0]       vid_rdata,
  output logic              vid_ack,
  output logic              mem_sel,
  output logic [3:0]        mem_wren,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int              WAIT_W   = $clog2(MAX_CPU_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_CPU_WAIT);

  arb_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              cpu_wins;
  logic              grant_cpu;
  logic              grant_vid;

  // Arbitration: video has priority unless the CPU has already lost too often
  always_comb begin
    cpu_wins  = cpu_sel && (!vid_req || (wait_cnt >= WAIT_MAX));
    grant_cpu = (state == ARB_IDLE) && cpu_wins;
    grant_vid = (state == ARB_IDLE) && !cpu_wins && vid_req;
  end

  // Saturating count of cycles a pending CPU request has gone unserved
  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      wait_cnt <= '0;
    end else if (!cpu_sel || grant_cpu || (state == ARB_BUSY_CPU)) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Transaction FSM: grant, hold the memory bus until ready, pulse the owner's completion
  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      state       <= ARB_IDLE;
      mem_sel     <= 1'b0;
      mem_wren    <= WREN_READ;
      mem_address <= '0;
      mem_wdata   <= '0;
      cpu_ready   <= 1'b0;
      vid_ack     <= 1'b0;
      cpu_rdata   <= '0;
      vid_rdata   <= '0;
    end else begin
      cpu_ready <= 1'b0;
      vid_ack   <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_cpu) begin
            mem_sel     <= 1'b1;
            mem_wren    <= cpu_wren;
            mem_address <= cpu_address;
            mem_wdata   <= cpu_wdata;
            state       <= ARB_BUSY_CPU;
          end else if (grant_vid) begin
            mem_sel     <= 1'b1;
            mem_wren    <= WREN_READ;
            mem_address <= vid_addr;
            mem_wdata   <= '0;
            state       <= ARB_BUSY_VID;
          end
        end
        ARB_BUSY_CPU: begin
          if (mem_ready) begin
            mem_sel   <= 1'b0;
            cpu_rdata <= mem_rdata;
            cpu_ready <= 1'b1;
            state     <= ARB_RESP;
          end
        end
        ARB_BUSY_VID: begin
          if (mem_ready) begin
            mem_sel   <= 1'b0;
            vid_rdata <= mem_rdata;
            vid_ack   <= 1'b1;
            state     <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_mem_arbiter.sv
// tb/tb_video_mem_arbiter.sv - directed self-checking bench for video_mem_arbiter
module tb_video_mem_arbiter;

  logic        clk_cpu = 1'b0;
  logic        n_reset;
  logic        cpu_sel;
  logic [3:0]  cpu_wren;
  logic [23:0] cpu_address;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        vid_req;
  logic [23:0] vid_addr;
  logic [31:0] vid_rdata;
  logic        vid_ack;
  logic        mem_sel;
  logic [3:0]  mem_wren;
  logic [23:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int passed = 0;

  video_mem_arbiter #(.ADDR_W(24), .MAX_CPU_WAIT(4)) dut (
    .clk_cpu     (clk_cpu),
    .n_reset     (n_reset),
    .cpu_sel     (cpu_sel),
    .cpu_wren    (cpu_wren),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_rdata   (vid_rdata),
    .vid_ack     (vid_ack),
    .mem_sel     (mem_sel),
    .mem_wren    (mem_wren),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    n_reset     = 1'b0;
    cpu_sel     = 1'b0;
    cpu_wren    = 4'b0000;
    cpu_address = '0;
    cpu_wdata   = '0;
    vid_req     = 1'b0;
    vid_addr    = '0;
    mem_rdata   = '0;
    mem_ready   = 1'b0;
    tick();
    tick();
    check("rst_mem_sel", {31'b0, mem_sel}, 32'd0);
    check("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
    check("rst_vid_ack", {31'b0, vid_ack}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_vid_rdata", vid_rdata, 32'd0);
    check("rst_mem_address", {8'b0, mem_address}, 32'd0);
    n_reset = 1'b1;
    tick();

    // CPU read alone
    cpu_sel = 1'b1; cpu_address = 24'h000100; cpu_wren = 4'b0000; cpu_wdata = 32'h12345678;
    tick();
    check("rd_grant_sel", {31'b0, mem_sel}, 32'd1);
    check("rd_grant_addr", {8'b0, mem_address}, 32'h000100);
    check("rd_grant_wren", {28'b0, mem_wren}, 32'd0);
    check("rd_no_early_ready", {31'b0, cpu_ready}, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    check("rd_ready", {31'b0, cpu_ready}, 32'd1);
    check("rd_rdata", cpu_rdata, 32'hDEADBEEF);
    check("rd_sel_drop", {31'b0, mem_sel}, 32'd0);
    cpu_sel = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
    tick();
    check("rd_ready_once", {31'b0, cpu_ready}, 32'd0);
    check("rd_rdata_hold", cpu_rdata, 32'hDEADBEEF);

    // CPU byte write with three wait cycles
    cpu_sel = 1'b1; cpu_address = 24'h000200; cpu_wren = 4'b0010; cpu_wdata = 32'h0000AB00;
    tick();
    check("wr_grant_wren", {28'b0, mem_wren}, 32'h2);
    check("wr_grant_wdata", mem_wdata, 32'h0000AB00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wr_hold_sel", {31'b0, mem_sel}, 32'd1);
      check("wr_hold_wren", {28'b0, mem_wren}, 32'h2);
      check("wr_hold_wdata", mem_wdata, 32'h0000AB00);
      check("wr_hold_addr", {8'b0, mem_address}, 32'h000200);
      check("wr_hold_no_ready", {31'b0, cpu_ready}, 32'd0);
    end
    mem_ready = 1'b1;
    tick();
    check("wr_ready", {31'b0, cpu_ready}, 32'd1);
    check("wr_sel_drop", {31'b0, mem_sel}, 32'd0);
    cpu_sel = 1'b0; mem_ready = 1'b0;
    tick();
    check("wr_ready_once", {31'b0, cpu_ready}, 32'd0);

    // Simultaneous requests: video first, then CPU in the following IDLE
    cpu_sel = 1'b1; cpu_address = 24'h000300; cpu_wren = 4'b0000;
    vid_req = 1'b1; vid_addr = 24'h800000;
    tick();
    check("sim_vid_addr", {8'b0, mem_address}, 32'h800000);
    check("sim_vid_wren", {28'b0, mem_wren}, 32'd0);
    check("sim_vid_wdata", mem_wdata, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    check("sim_vid_ack", {31'b0, vid_ack}, 32'd1);
    check("sim_vid_rdata", vid_rdata, 32'hCAFEF00D);
    check("sim_no_cpu_ready", {31'b0, cpu_ready}, 32'd0);
    vid_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("sim_resp_no_grant", {31'b0, mem_sel}, 32'd0);
    check("sim_vid_ack_once", {31'b0, vid_ack}, 32'd0);
    tick();
    check("sim_cpu_grant", {31'b0, mem_sel}, 32'd1);
    check("sim_cpu_addr", {8'b0, mem_address}, 32'h000300);
    mem_ready = 1'b1; mem_rdata = 32'h11111111;
    tick();
    check("sim_cpu_ready", {31'b0, cpu_ready}, 32'd1);
    check("sim_cpu_rdata", cpu_rdata, 32'h11111111);
    cpu_sel = 1'b0; mem_ready = 1'b0;
    tick();

    // Starvation bound with continuous video requests and an always-ready memory
    vid_req = 1'b1; vid_addr = 24'h800010;
    cpu_sel = 1'b1; cpu_address = 24'h000400; cpu_wren = 4'b0000;
    mem_ready = 1'b1; mem_rdata = 32'h22222222;
    tick();
    check("stv_g1_vid", {8'b0, mem_address}, 32'h800010);
    tick();
    check("stv_g1_ack", {31'b0, vid_ack}, 32'd1);
    tick();
    check("stv_resp_idle", {31'b0, mem_sel}, 32'd0);
    tick();
    check("stv_g2_sel", {31'b0, mem_sel}, 32'd1);
    check("stv_g2_vid", {8'b0, mem_address}, 32'h800010);
    tick();
    check("stv_g2_ack", {31'b0, vid_ack}, 32'd1);
    check("stv_g2_no_cpu", {31'b0, cpu_ready}, 32'd0);
    tick();
    tick();
    check("stv_g3_cpu", {8'b0, mem_address}, 32'h000400);
    check("stv_g3_sel", {31'b0, mem_sel}, 32'd1);
    tick();
    check("stv_cpu_ready", {31'b0, cpu_ready}, 32'd1);
    check("stv_cpu_rdata", cpu_rdata, 32'h22222222);
    cpu_sel = 1'b0;
    tick();
    tick();
    check("stv_g4_vid", {8'b0, mem_address}, 32'h800010);
    vid_req = 1'b0;
    tick();
    check("stv_g4_ack", {31'b0, vid_ack}, 32'd1);
    mem_ready = 1'b0;
    tick();
    tick();
    check("stv_idle", {31'b0, mem_sel}, 32'd0);

    // Stray mem_ready in IDLE
    mem_ready = 1'b1; mem_rdata = 32'h99999999;
    tick();
    check("stray_no_cpu_ready", {31'b0, cpu_ready}, 32'd0);
    check("stray_no_vid_ack", {31'b0, vid_ack}, 32'd0);
    check("stray_no_sel", {31'b0, mem_sel}, 32'd0);
    check("stray_rdata_hold", cpu_rdata, 32'h22222222);
    mem_ready = 1'b0;

    // CPU request dropped before it is granted
    vid_req = 1'b1; vid_addr = 24'h800020;
    tick();
    check("drop_vid_grant", {8'b0, mem_address}, 32'h800020);
    cpu_sel = 1'b1; cpu_address = 24'h000500;
    tick();
    cpu_sel = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h33333333;
    tick();
    check("drop_vid_ack", {31'b0, vid_ack}, 32'd1);
    vid_req = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    check("drop_no_sel", {31'b0, mem_sel}, 32'd0);
    check("drop_addr_unchanged", {8'b0, mem_address}, 32'h800020);
    tick();
    check("drop_no_ready", {31'b0, cpu_ready}, 32'd0);

    // Reset in the middle of a video transaction
    vid_req = 1'b1; vid_addr = 24'h800030;
    tick();
    check("mid_busy_sel", {31'b0, mem_sel}, 32'd1);
    n_reset = 1'b0;
    #1;
    check("mid_rst_sel", {31'b0, mem_sel}, 32'd0);
    check("mid_rst_ack", {31'b0, vid_ack}, 32'd0);
    check("mid_rst_addr", {8'b0, mem_address}, 32'd0);
    check("mid_rst_vid_rdata", vid_rdata, 32'd0);
    check("mid_rst_cpu_rdata", cpu_rdata, 32'd0);
    vid_req = 1'b0;
    tick();
    n_reset = 1'b1;
    cpu_sel = 1'b1; cpu_address = 24'h000600; cpu_wren = 4'b0000;
    tick();
    check("post_rst_grant", {8'b0, mem_address}, 32'h000600);
    mem_ready = 1'b1; mem_rdata = 32'h44444444;
    tick();
    check("post_rst_ready", {31'b0, cpu_ready}, 32'd1);
    check("post_rst_rdata", cpu_rdata, 32'h44444444);
    cpu_sel = 1'b0; mem_ready = 1'b0;
    tick();
    check("post_rst_ready_once", {31'b0, cpu_ready}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
